// File: rtl/axi_master_wr_pkg.sv
// axi_master_wr_pkg: shared AXI write constants, FSM encoding and burst sizing helper
package axi_master_wr_pkg;
  localparam logic [2:0] AXI_SIZE = 3'b111;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [3:0] AXI_CACHE = 4'd3;
  localparam int BEAT_BYTES = 128;
  localparam int MAX_BURST = 32;
  typedef enum logic [1:0] {IDLE, ADDR, HOLD, FLUSH} state_t;
  // slot is the beat index within the 4 KB page, so the page holds MAX_BURST - slot more beats
  function automatic logic [5:0] burst_beats(input logic [15:0] rem, input logic [4:0] slot);
    logic [5:0] room;
    room = 6'(MAX_BURST) - {1'b0, slot};
    return (rem < {10'd0, room}) ? rem[5:0] : room;
  endfunction
endpackage

// File: rtl/axi_master_wr_len_fifo.sv
// wr_len_fifo: burst-length queue linking each accepted AW burst to its W beats
module wr_len_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  assign dout = mem[rp];
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == LAST ? '0 : wp + PW'(1);
      if (pop) rp <= rp == LAST ? '0 : rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/axi_master_wr.sv
// axi_master_wr: streams a job of 128-byte beats from a show-ahead FIFO as 4 KB-safe AXI write bursts
module axi_master_wr
  import axi_master_wr_pkg::*;
#(
  parameter int ID_WIDTH = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 1024,
  parameter int AWUSER_WIDTH = 8,
  parameter int MAX_OUTST = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               i_snap_context,
  input  logic                      start_pulse,
  input  logic [63:0]               target_address,
  input  logic [15:0]               total_beats,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  output logic                      fifo_rd,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [3:0]                m_axi_awcache,
  output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic [1:0]                m_axi_awlock,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      wr_done,
  output logic                      wr_error
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTST);
  state_t state;
  logic [15:0] rem, rem_n;
  logic [CW-1:0] out_cnt, out_n, q_cnt, q_n;
  logic [5:0] beats, nxt_beats, q_dout, wcnt;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic aw_hs, b_hs, w_hs, pop, q_empty, unused;
  assign unused = ^{m_axi_bid, i_snap_context};
  assign m_axi_awsize = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_awuser = i_snap_context[AWUSER_WIDTH-1:0];
  assign m_axi_awprot = 3'd0;
  assign m_axi_awqos = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awlock = 2'b00;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign b_hs = m_axi_bvalid & m_axi_bready;
  assign beats = m_axi_awlen[5:0] + 6'd1;
  assign rem_n = rem - 16'(beats);
  assign addr_n = m_axi_awaddr + ADDR_WIDTH'(int'(beats) * BEAT_BYTES);
  assign nxt_beats = burst_beats(rem_n, addr_n[11:7]);
  assign out_n = out_cnt + CW'(aw_hs) - CW'(b_hs && out_cnt != '0);
  assign q_n = q_cnt + CW'(aw_hs) - CW'(pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_awlen <= '0;
      m_axi_awid <= '0;
      m_axi_bready <= 1'b0;
      rem <= '0;
      out_cnt <= '0;
      wr_done <= 1'b0;
      wr_error <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      out_cnt <= out_n;
      if (b_hs && m_axi_bresp != 2'b00) wr_error <= 1'b1;
      case (state)
        IDLE: if (start_pulse) begin
          wr_error <= 1'b0;
          m_axi_awid <= '0;
          if (total_beats == '0) wr_done <= 1'b1;
          else begin
            state <= ADDR;
            m_axi_awvalid <= 1'b1;
            m_axi_bready <= 1'b1;
            m_axi_awaddr <= ADDR_WIDTH'(target_address);
            m_axi_awlen <= 8'(burst_beats(total_beats, target_address[11:7]) - 6'd1);
            rem <= total_beats;
          end
        end
        ADDR: if (aw_hs) begin
          m_axi_awid <= m_axi_awid + ID_WIDTH'(1);
          m_axi_awaddr <= addr_n;
          m_axi_awlen <= 8'(nxt_beats - 6'd1);
          rem <= rem_n;
          if (rem_n == '0) begin
            state <= FLUSH;
            m_axi_awvalid <= 1'b0;
          end else if (out_n == MAXO || q_n == MAXO) begin
            state <= HOLD;
            m_axi_awvalid <= 1'b0;
          end
        end
        HOLD: if (out_cnt < MAXO && q_cnt < MAXO) begin
          state <= ADDR;
          m_axi_awvalid <= 1'b1;
        end
        FLUSH: if (out_cnt == '0 && q_empty) begin
          state <= IDLE;
          m_axi_bready <= 1'b0;
          wr_done <= 1'b1;
        end
      endcase
    end
  // W side is combinational off the length queue head so wvalid tracks FIFO data directly
  assign m_axi_wvalid = !q_empty & !fifo_empty;
  assign m_axi_wdata = fifo_dout;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = !q_empty && wcnt == q_dout - 6'd1;
  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign fifo_rd = w_hs;
  assign pop = w_hs & m_axi_wlast;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= '0;
    else wcnt <= pop ? '0 : w_hs ? wcnt + 6'd1 : wcnt;
  wr_len_fifo #(.DEPTH(MAX_OUTST), .WIDTH(6)) u_len_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(aw_hs),
    .din(beats),
    .pop(pop),
    .dout(q_dout),
    .empty(q_empty),
    .count(q_cnt)
  );
endmodule

// File: tb/tb_axi_master_wr.sv
// tb_axi_master_wr: job table plus random jobs against a burst-splitting reference model and AXI slave model
module tb_axi_master_wr;
  localparam int IDW = 2, AW = 64, DW = 1024, UW = 8, MO = 8;
  typedef struct {
    logic [63:0] target;
    int total;
    bit rnd;
    bit hold;
    bit err;
    int n_aw;
  } job_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [31:0] i_snap_context = 32'hDEAD_BE5A;
  logic start_pulse = 0, fifo_empty = 0, fifo_rd;
  logic [63:0] target_address = 0;
  logic [15:0] total_beats = 0;
  logic [DW-1:0] fifo_dout = 0;
  logic [IDW-1:0] m_axi_awid, m_axi_bid = 0;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic m_axi_awvalid, m_axi_awready = 0, m_axi_wlast, m_axi_wvalid, m_axi_wready = 0;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst, m_axi_awlock, m_axi_bresp = 0;
  logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_awregion;
  logic [UW-1:0] m_axi_awuser;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_bvalid = 0, m_axi_bready, wr_done, wr_error;
  axi_master_wr dut (
    .clk(clk), .rst_n(rst_n), .i_snap_context(i_snap_context), .start_pulse(start_pulse),
    .target_address(target_address), .total_beats(total_beats), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awuser(m_axi_awuser), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awlock(m_axi_awlock), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .wr_done(wr_done), .wr_error(wr_error)
  );
  int checks = 0, passes = 0;
  int aw_n, w_n, b_n, done_cnt, exp_beat = 0, rd_idx = 0, avail = 3, slv_beat = 0;
  logic [63:0] exp_addr[$];
  int exp_len[$], slv_len[$];
  logic [IDW-1:0] slv_id[$], slv_bid[$];
  bit rnd = 0, b_hold = 0, err_next = 0, go = 0, b_fire = 0, prev_ws = 0, prev_as = 0;
  logic [DW-1:0] prev_wd;
  logic [AW-1:0] prev_aa;
  logic [7:0] prev_al;
  logic [IDW-1:0] prev_ai;
  job_t jobs[6];

  function automatic logic [DW-1:0] pat(input int k);
    return {32{32'hC0DE0000 + 32'(k)}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // bursts split by remaining length, 32-beat cap and the 4 KB page boundary
  task automatic build_model(input logic [63:0] target, input int total);
    logic [63:0] a;
    int rem, nb, room;
    exp_addr.delete();
    exp_len.delete();
    a = target;
    rem = total;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 128;
      nb = rem < 32 ? rem : 32;
      if (room < nb) nb = room;
      exp_addr.push_back(a);
      exp_len.push_back(nb - 1);
      a += 64'(nb) * 128;
      rem -= nb;
    end
  endtask

  task automatic monitor();
    bit exp_last;
    if (prev_ws) begin
      chk("w_hold_valid", m_axi_wvalid, 1);
      chk("w_hold_data", m_axi_wdata === prev_wd, 1);
    end
    if (prev_as) begin
      chk("aw_hold_valid", m_axi_awvalid, 1);
      chk("aw_hold_addr", m_axi_awaddr, prev_aa);
      chk("aw_hold_len", m_axi_awlen, prev_al);
      chk("aw_hold_id", m_axi_awid, prev_ai);
    end
    prev_ws = m_axi_wvalid && !m_axi_wready;
    prev_wd = m_axi_wdata;
    prev_as = m_axi_awvalid && !m_axi_awready;
    prev_aa = m_axi_awaddr;
    prev_al = m_axi_awlen;
    prev_ai = m_axi_awid;
    chk("fifo_rd", fifo_rd, m_axi_wvalid && m_axi_wready);
    if (m_axi_awvalid && m_axi_awready) begin
      if (aw_n < exp_addr.size()) begin
        chk("awaddr", m_axi_awaddr, exp_addr[aw_n]);
        chk("awlen", m_axi_awlen, exp_len[aw_n]);
        chk("awid", m_axi_awid, aw_n % 4);
      end else chk("aw_extra", aw_n, exp_addr.size());
      chk("outstanding_limit", (aw_n - b_n) < MO, 1);
      chk("bready_busy", m_axi_bready, 1);
      slv_len.push_back(int'(m_axi_awlen));
      slv_id.push_back(m_axi_awid);
      aw_n++;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      chk("w_after_aw", slv_len.size() > 0, 1);
      checks++;
      if (m_axi_wdata === pat(exp_beat)) passes++;
      else $display("FAIL wdata: got 0x%0h expected 0x%0h", m_axi_wdata[31:0], pat(exp_beat) & 32'hFFFFFFFF);
      exp_last = slv_len.size() > 0 && slv_beat == slv_len[0];
      chk("wlast", m_axi_wlast, exp_last);
      if (exp_last) begin
        slv_len.pop_front();
        slv_bid.push_back(slv_id.pop_front());
        slv_beat = 0;
      end else slv_beat++;
      w_n++;
      exp_beat++;
    end
    if (fifo_rd) begin
      rd_idx++;
      avail--;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_fire = 1;
      void'(slv_bid.pop_front());
      b_n++;
    end
    if (wr_done) done_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    start_pulse = go;
    go = 0;
    m_axi_awready = !rnd || ($urandom_range(0, 2) != 0);
    m_axi_wready = !rnd || ($urandom_range(0, 2) != 0);
    if (avail < 6 && (!rnd || $urandom_range(0, 1) == 1)) avail++;
    fifo_empty = avail == 0;
    fifo_dout = pat(rd_idx);
    if (b_fire) m_axi_bvalid = 0;
    b_fire = 0;
    if (!m_axi_bvalid && slv_bid.size() > 0 && !b_hold && (!rnd || $urandom_range(0, 1) == 1)) begin
      m_axi_bvalid = 1;
      m_axi_bid = slv_bid[0];
      m_axi_bresp = err_next ? 2'b10 : 2'b00;
      err_next = 0;
    end
    #1;
    monitor();
  endtask

  task automatic run_job(input job_t j);
    int t, naw;
    build_model(j.target, j.total);
    naw = j.n_aw >= 0 ? j.n_aw : exp_addr.size();
    aw_n = 0; w_n = 0; b_n = 0; done_cnt = 0;
    rnd = j.rnd; b_hold = j.hold; err_next = j.err;
    target_address = j.target;
    total_beats = 16'(j.total);
    go = 1;
    if (j.hold) begin
      repeat (400) step();
      chk("hold_aw_count", aw_n, naw < MO ? naw : MO);
      chk("hold_awvalid", m_axi_awvalid, 0);
      b_hold = 0;
    end
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      step();
      t++;
    end
    chk("done_timeout", done_cnt != 0, 1);
    repeat (5) step();
    chk("aw_count", aw_n, naw);
    chk("w_beats", w_n, j.total);
    chk("b_count", b_n, naw);
    chk("done_once", done_cnt, 1);
    chk("wr_error_end", wr_error, j.err);
    chk("bready_idle", m_axi_bready, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_wvalid"}, m_axi_wvalid, 0);
    chk({tag, "_wlast"}, m_axi_wlast, 0);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_bready"}, m_axi_bready, 0);
    chk({tag, "_awid"}, m_axi_awid, 0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 0);
    chk({tag, "_awlen"}, m_axi_awlen, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_wr_error"}, wr_error, 0);
  endtask

  initial begin
    job_t j;
    jobs[0] = '{64'h1000, 64, 1'b0, 1'b0, 1'b0, 2};
    jobs[1] = '{64'h1F80, 4, 1'b0, 1'b0, 1'b0, 2};
    jobs[2] = '{64'h0, 320, 1'b0, 1'b1, 1'b0, 10};
    jobs[3] = '{64'h2_0000_0F00, 100, 1'b1, 1'b0, 1'b0, 5};
    jobs[4] = '{64'h7E80, 33, 1'b1, 1'b1, 1'b0, 2};
    jobs[5] = '{64'h3000_0000, 40, 1'b1, 1'b0, 1'b1, 2};
    #12;
    chk_reset("rst");
    chk("awsize", m_axi_awsize, 3'b111);
    chk("awburst", m_axi_awburst, 2'd1);
    chk("awcache", m_axi_awcache, 4'd3);
    chk("awuser", m_axi_awuser, 8'h5A);
    chk("awprot_qos_region_lock", {m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awlock}, 0);
    chk("wstrb", m_axi_wstrb === '1, 1);
    @(negedge clk);
    rst_n = 1;
    foreach (jobs[i]) run_job(jobs[i]);
    // zero-length job: immediate done, clears the error left by the previous job
    chk("err_before_zero", wr_error, 1);
    target_address = 0;
    total_beats = 0;
    done_cnt = 0;
    go = 1;
    step();
    chk("zero_done_early", wr_done, 0);
    step();
    chk("zero_done", wr_done, 1);
    chk("zero_err_clear", wr_error, 0);
    chk("zero_awvalid", m_axi_awvalid, 0);
    step();
    chk("zero_done_pulse", wr_done, 0);
    chk("zero_bready", m_axi_bready, 0);
    repeat (4) begin
      j.target = {$urandom_range(0, 4095), 7'b0};
      j.total = $urandom_range(1, 150);
      j.rnd = 1;
      j.hold = 0;
      j.err = 1'($urandom_range(0, 1));
      j.n_aw = -1;
      run_job(j);
    end
    // reset in the middle of a job
    build_model(64'h4000, 64);
    aw_n = 0; w_n = 0; b_n = 0; done_cnt = 0;
    rnd = 1; b_hold = 0; err_next = 0;
    target_address = 64'h4000;
    total_beats = 64;
    go = 1;
    repeat (30) step();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_reset("midrst");
    m_axi_bvalid = 0;
    b_fire = 0; prev_ws = 0; prev_as = 0; slv_beat = 0;
    slv_len.delete(); slv_id.delete(); slv_bid.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      step();
      chk("post_rst_awvalid", m_axi_awvalid, 0);
      chk("post_rst_wvalid", m_axi_wvalid, 0);
    end
    j = '{64'h5000, 48, 1'b1, 1'b0, 1'b0, 2};
    run_job(j);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
